// File: rtl/assoc_mem_rr.sv
// assoc_mem_rr: small fully-associative tag/data store with valid bits.
// Supports read, write-allocate with round-robin victim replacement, single-entry
// invalidate and a sequential flush-all. One request is taken at a time via req/ready.
//
// Ports:
//   clock, reset_n    clock (rising edge) and asynchronous active-low reset
//   req, op           request valid and opcode (00 read, 01 write, 10 invalidate, 11 flush)
//   address, dataIn   lookup tag and write data
//   ready             high only while idle
//   done              one-cycle completion pulse; dataOut/hit/evicted update with it
//   dataOut           read result (holds for write, invalidate and flush)
//   hit, evicted      tag matched a valid entry / a write miss replaced a valid entry
//   occupancy         number of valid entries
module assoc_mem_rr #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req,
  input  logic [1:0]                 op,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          dataIn,
  output logic                       ready,
  output logic                       done,
  output logic [DATA_W-1:0]          dataOut,
  output logic                       hit,
  output logic                       evicted,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH+1);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpInval = 2'b10;
  localparam logic [1:0] OpFlush = 2'b11;

  typedef enum logic [1:0] {StIdle, StLookup, StFlush} state_e;

  state_e              state_q, state_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ADDR_W-1:0]   tag_q [DEPTH];
  logic [ADDR_W-1:0]   tag_d [DEPTH];
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [IdxW-1:0]     victim_q, victim_d;
  logic [IdxW-1:0]     flush_idx_q, flush_idx_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  // Results are staged for one cycle so they become visible together with done.
  logic                fin_q, fin_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_hit_q, res_hit_d;
  logic                res_evict_q, res_evict_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                hit_q, hit_d;
  logic                evicted_q, evicted_d;

  logic                match_any, free_any;
  logic [IdxW-1:0]     match_idx, free_idx;
  logic [OccW-1:0]     occ;

  // Lowest-index valid match and lowest-index free slot.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!match_any && valid_q[i] && (tag_q[i] == addr_q)) begin
        match_any = 1'b1;
        match_idx = IdxW'(i);
      end
      if (!free_any && !valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ = occ + OccW'(valid_q[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    mem_d       = mem_q;
    victim_d    = victim_q;
    flush_idx_d = flush_idx_q;
    op_d        = op_q;
    addr_d      = addr_q;
    din_d       = din_q;
    fin_d       = 1'b0;
    res_data_d  = res_data_q;
    res_hit_d   = res_hit_q;
    res_evict_d = res_evict_q;
    done_d      = fin_q;
    data_out_d  = data_out_q;
    hit_d       = hit_q;
    evicted_d   = evicted_q;

    // op_q still holds the completing op here: a new accept replaces it on this same edge.
    if (fin_q) begin
      hit_d     = res_hit_q;
      evicted_d = res_evict_q;
      if (op_q == OpRead) begin
        data_out_d = res_data_q;
      end
    end

    case (state_q)
      StIdle: begin
        if (req) begin
          op_d   = op;
          addr_d = address;
          din_d  = dataIn;
          if (op == OpFlush) begin
            state_d     = StFlush;
            flush_idx_d = '0;
          end else begin
            state_d = StLookup;
          end
        end
      end

      StLookup: begin
        state_d     = StIdle;
        fin_d       = 1'b1;
        res_hit_d   = match_any;
        res_evict_d = 1'b0;
        case (op_q)
          OpRead: begin
            res_data_d = match_any ? mem_q[match_idx] : '0;
          end
          OpWrite: begin
            if (match_any) begin
              mem_d[match_idx] = din_q;
            end else if (free_any) begin
              valid_d[free_idx] = 1'b1;
              tag_d[free_idx]   = addr_q;
              mem_d[free_idx]   = din_q;
            end else begin
              tag_d[victim_q] = addr_q;
              mem_d[victim_q] = din_q;
              res_evict_d     = 1'b1;
              victim_d        = (victim_q == IdxW'(DEPTH-1)) ? '0 : victim_q + 1'b1;
            end
          end
          OpInval: begin
            if (match_any) begin
              valid_d[match_idx] = 1'b0;
            end
          end
          default: ;
        endcase
      end

      StFlush: begin
        valid_d[flush_idx_q] = 1'b0;
        if (flush_idx_q == IdxW'(DEPTH-1)) begin
          state_d     = StIdle;
          fin_d       = 1'b1;
          victim_d    = '0;
          res_hit_d   = 1'b0;
          res_evict_d = 1'b0;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        mem_q[i] <= '0;
      end
      victim_q    <= '0;
      flush_idx_q <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      fin_q       <= 1'b0;
      res_data_q  <= '0;
      res_hit_q   <= 1'b0;
      res_evict_q <= 1'b0;
      done_q      <= 1'b0;
      data_out_q  <= '0;
      hit_q       <= 1'b0;
      evicted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      mem_q       <= mem_d;
      victim_q    <= victim_d;
      flush_idx_q <= flush_idx_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      fin_q       <= fin_d;
      res_data_q  <= res_data_d;
      res_hit_q   <= res_hit_d;
      res_evict_q <= res_evict_d;
      done_q      <= done_d;
      data_out_q  <= data_out_d;
      hit_q       <= hit_d;
      evicted_q   <= evicted_d;
    end
  end

  assign ready     = (state_q == StIdle);
  assign done      = done_q;
  assign dataOut   = data_out_q;
  assign hit       = hit_q;
  assign evicted   = evicted_q;
  assign occupancy = occ;

endmodule
